// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared definitions for the pattern scan controller: default sizes, state
// encoding and an index-width helper used by the RTL and its bench.
package pattern_scan_ctrl_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CLR   = 2'd1;
  localparam state_t ST_SHIFT = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Index width that stays at least one bit wide for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Requester and detector signal bundle for pattern_scan_ctrl; master is the
// controller side, slave is the requester/detector side.
interface pattern_scan_ctrl_if
  import pattern_scan_ctrl_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
);
  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(WIDTH + 1);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       gnt;
  logic                  det_rst;
  logic                  det_en;
  logic                  det_din;
  logic                  det_hit;
  logic                  done;
  logic [IW-1:0]         done_id;
  logic [CW-1:0]         hit_cnt;
  logic                  busy;

  modport master (
    input  req, data, det_hit,
    output gnt, det_rst, det_en, det_din, done, done_id, hit_cnt, busy
  );

  modport slave (
    output req, data, det_hit,
    input  gnt, det_rst, det_en, det_din, done, done_id, hit_cnt, busy
  );
endinterface

// File: rtl/pattern_scan_ctrl_rr_arbiter.sv
// Round-robin arbiter: searches upward from the index after i_last and
// returns a one-hot winner (all zero when nothing is requesting).
module rr_arbiter
  import pattern_scan_ctrl_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_gnt
);

  always_comb begin
    int w_pos;
    o_gnt = '0;
    w_pos = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_pos = (int'(i_last) + k) % NREQ;
      if (o_gnt == '0 && i_req[w_pos]) begin
        o_gnt[w_pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Shares one serial pattern detector among NREQ requesters: grants one word,
// clears the detector, shifts the word MSB first and reports the hit count.
module pattern_scan_ctrl
  import pattern_scan_ctrl_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  pattern_scan_ctrl_if.master bus
);

  localparam int IW = idx_w(NREQ);
  localparam int BW = idx_w(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [IW-1:0]    r_last;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_word;
  logic [BW-1:0]    r_bit;
  logic [CW-1:0]    r_hits;
  logic [IW-1:0]    r_done_id;
  logic [CW-1:0]    r_hit_out;

  logic [NREQ-1:0]  w_arb_gnt;
  logic [IW-1:0]    w_win_idx;
  logic [WIDTH-1:0] w_win_word;
  logic [WIDTH-1:0] w_slice [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign w_slice[gi] = bus.data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .i_req  (bus.req),
    .i_last (r_last),
    .o_gnt  (w_arb_gnt)
  );

  always_comb begin
    w_win_idx  = '0;
    w_win_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_arb_gnt[i]) begin
        w_win_idx  = IW'(i);
        w_win_word = w_slice[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_last    <= IW'(NREQ - 1);  // makes req[0] the first candidate
      r_idx     <= '0;
      r_word    <= '0;
      r_bit     <= '0;
      r_hits    <= '0;
      r_done_id <= '0;
      r_hit_out <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|bus.req) begin
            r_word  <= w_win_word;
            r_idx   <= w_win_idx;
            r_last  <= w_win_idx;
            r_state <= ST_CLR;
          end
        end
        ST_CLR: begin
          r_hits  <= '0;
          r_bit   <= '0;
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_word <= r_word << 1;
          r_bit  <= r_bit + 1'b1;
          r_hits <= r_hits + CW'(bus.det_hit);
          if (r_bit == BW'(WIDTH - 1)) begin
            // Fold in the final cycle's hit so the reported count is complete.
            r_hit_out <= r_hits + CW'(bus.det_hit);
            r_done_id <= r_idx;
            r_state   <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are forced to their idle values in the cycle reset is raised.
  assign bus.gnt     = (!reset && r_state == ST_IDLE) ? w_arb_gnt : '0;
  assign bus.det_rst = reset || (r_state == ST_CLR);
  assign bus.det_en  = !reset && (r_state == ST_SHIFT);
  assign bus.det_din = bus.det_en && r_word[WIDTH-1];
  assign bus.done    = !reset && (r_state == ST_DONE);
  assign bus.busy    = !reset && (r_state != ST_IDLE);
  assign bus.done_id = reset ? '0 : r_done_id;
  assign bus.hit_cnt = reset ? '0 : r_hit_out;

endmodule
